// File: rtl/aux_boot_pkg.sv
// Shared types and helpers for the auxiliary UART boot loader.
//   rx_state_t   : receiver FSM states
//   byte_t/word_t: received byte and assembled 32-bit program word
//   clks_per_bit : clock cycles per UART bit for a given clock/baud pair
package aux_boot_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    function automatic int unsigned clks_per_bit(int unsigned freq, int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/aux_uart_boot_loader_if.sv
// Program-memory write port driven by the boot loader.
//   mem_we    : 1-cycle write strobe
//   mem_addr  : word address, valid with mem_we, held otherwise
//   mem_wdata : write data, valid with mem_we, held otherwise
// master = loader side (drives), slave = memory side (receives).
interface aux_uart_boot_loader_if
    import aux_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    word_t                 mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/aux_uart_boot_loader_uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, with 2-flop input synchronizer.
//   clk, resetb : clock, synchronous active-low reset
//   en          : start edges are accepted only while high
//   rx          : asynchronous RX line, idle high
//   byte_valid  : 1-cycle pulse, byte_data holds the received byte
//   byte_data   : last shifted-in byte
//   frame_err   : 1-cycle pulse when the stop bit is sampled low (byte dropped)
//   start_edge  : 1-cycle pulse when a start edge is accepted in IDLE
//   idle        : receiver FSM is in IDLE
module uart_rx_byte
    import aux_boot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic  clk,
    input  logic  resetb,
    input  logic  en,
    input  logic  rx,
    output logic  byte_valid,
    output byte_t byte_data,
    output logic  frame_err,
    output logic  start_edge,
    output logic  idle
);

    localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    byte_t           shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        start_edge = 1'b0;
        idle       = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && !rx_sync_q) begin
                    start_edge = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                // Mid start bit: a line back high means a glitch, not a frame.
                if (cnt_q == CntHalf) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CntFull) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/aux_uart_boot_loader.sv
// Auxiliary UART boot loader: receives a program image (8N1, LSB first) and writes it as
// little-endian 32-bit words into program memory from word address 0, holding the core in
// reset (boot_busy) until an idle timeout ends the load.
//   clk, resetb  : clock, synchronous active-low reset
//   enable       : sampled in the first cycle after reset; 0 bypasses the loader
//   aux_uart_rx  : asynchronous UART RX line, idle high
//   boot_busy    : high while loading
//   boot_done    : sticky, load ended by timeout
//   err_frame    : sticky, a stop bit was sampled low
//   err_partial  : sticky, timeout hit with an unfinished word
//   err_wrap     : sticky, word address wrapped to 0
//   mem          : memory write port (master)
module aux_uart_boot_loader
    import aux_boot_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned TIMEOUT_BITS  = 1024
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    aux_uart_rx,
    output logic                    boot_busy,
    output logic                    boot_done,
    output logic                    err_frame,
    output logic                    err_partial,
    output logic                    err_wrap,
    aux_uart_boot_loader_if.master  mem
);

    localparam int unsigned     CPB      = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned     TmoLimit = TIMEOUT_BITS * CPB;
    localparam int unsigned     TmoW     = $clog2(TmoLimit + 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TmoLimit - 1);

    logic  rx_valid, rx_ferr, rx_start, rx_idle, rx_en;
    byte_t rx_byte;

    logic                  sampled_q, sampled_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tmo_armed_q, tmo_armed_d;
    logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    word_t                 word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    word_t                 wdata_q, wdata_d;
    logic                  err_frame_q, err_frame_d;
    logic                  err_partial_q, err_partial_d;
    logic                  err_wrap_q, err_wrap_d;

    // Receiver runs only once enable has been sampled and the load is still in progress.
    assign rx_en = busy_q && sampled_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) u_rx (
        .clk        (clk),
        .resetb     (resetb),
        .en         (rx_en),
        .rx         (aux_uart_rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_ferr),
        .start_edge (rx_start),
        .idle       (rx_idle)
    );

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sampled_q     <= 1'b0;
            busy_q        <= enable;
            done_q        <= 1'b0;
            tmo_armed_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            err_frame_q   <= 1'b0;
            err_partial_q <= 1'b0;
            err_wrap_q    <= 1'b0;
        end else begin
            sampled_q     <= sampled_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tmo_armed_q   <= tmo_armed_d;
            tmo_cnt_q     <= tmo_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            err_frame_q   <= err_frame_d;
            err_partial_q <= err_partial_d;
            err_wrap_q    <= err_wrap_d;
        end
    end

    always_comb begin
        sampled_d     = 1'b1;
        busy_d        = busy_q;
        done_d        = done_q;
        tmo_armed_d   = tmo_armed_q;
        tmo_cnt_d     = tmo_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        addr_d        = addr_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        err_frame_d   = err_frame_q;
        err_partial_d = err_partial_q;
        err_wrap_d    = err_wrap_q;

        if (!sampled_q) begin
            busy_d = enable;
        end

        // Word assembly: byte k lands in bits [8k+7:8k]; the 4th byte issues the write.
        if (rx_valid) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
            byte_cnt_d  = byte_cnt_q + 2'd1;
            tmo_armed_d = 1'b1;
            if (byte_cnt_q == 2'd3) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = word_d;
                addr_d  = addr_q + 1'b1;
                if (addr_q == '1) begin
                    err_wrap_d = 1'b1;
                end
            end
        end

        if (rx_ferr) begin
            err_frame_d = 1'b1;
            tmo_armed_d = 1'b1;
        end

        // Idle timeout; a start edge in the same cycle takes priority and clears it.
        if (rx_start) begin
            tmo_cnt_d = '0;
        end else if (tmo_armed_q && rx_idle && rx_en) begin
            if (tmo_cnt_q == TmoLast) begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                tmo_cnt_d  = '0;
                byte_cnt_d = '0;
                if (byte_cnt_q != 2'd0) begin
                    err_partial_d = 1'b1;
                end
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    assign boot_busy     = busy_q;
    assign boot_done     = done_q;
    assign err_frame     = err_frame_q;
    assign err_partial   = err_partial_q;
    assign err_wrap      = err_wrap_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = waddr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Bench for aux_uart_boot_loader: 8 clks/bit, 16-bit-period timeout, 8-word memory.
module tb_aux_uart_boot_loader;

    localparam int unsigned CPB   = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned Words = 1 << AW;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic enable = 1'b1;
    logic rx = 1'b1;
    logic boot_busy, boot_done, err_frame, err_partial, err_wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    bit          tx_ok[$];
    logic [31:0] obs_addr[$], obs_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    bit          exp_wrap, exp_partial, exp_frame, exp_any;

    aux_uart_boot_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

    aux_uart_boot_loader #(
        .CLK_FREQUENCY (800),
        .BAUD_RATE     (100),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_BITS  (16)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .enable      (enable),
        .aux_uart_rx (rx),
        .boot_busy   (boot_busy),
        .boot_done   (boot_done),
        .err_frame   (err_frame),
        .err_partial (err_partial),
        .err_wrap    (err_wrap),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_if.mem_we === 1'b1) begin
            obs_addr.push_back(32'(mem_if.mem_addr));
            obs_data.push_back(mem_if.mem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(ok);
        rx = 1'b1;
        // After a low stop bit, let the line idle so the receiver realigns.
        if (!ok) repeat (2 * CPB) @(negedge clk);
        tx_q.push_back(b);
        tx_ok.push_back(ok);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic clear_queues();
        tx_q.delete();
        tx_ok.delete();
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic check_reset_state(input string tag, input logic en);
        check({tag, " busy"}, 32'(boot_busy), 32'(en));
        check({tag, " done"}, 32'(boot_done), 32'd0);
        check({tag, " err_frame"}, 32'(err_frame), 32'd0);
        check({tag, " err_partial"}, 32'(err_partial), 32'd0);
        check({tag, " err_wrap"}, 32'(err_wrap), 32'd0);
        check({tag, " mem_we"}, 32'(mem_if.mem_we), 32'd0);
        check({tag, " mem_addr"}, 32'(mem_if.mem_addr), 32'd0);
        check({tag, " mem_wdata"}, mem_if.mem_wdata, 32'd0);
    endtask

    task automatic do_reset(input string tag, input logic en);
        @(negedge clk);
        resetb = 1'b0;
        enable = en;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state(tag, en);
        resetb = 1'b1;
        clear_queues();
        repeat (2) @(negedge clk);
    endtask

    // Reference: valid bytes pack four at a time little-endian into words at
    // consecutive addresses modulo memory size.
    task automatic build_model();
        logic [7:0] v[$];
        int nw;
        exp_addr.delete();
        exp_data.delete();
        exp_frame = 1'b0;
        foreach (tx_q[i]) begin
            if (tx_ok[i]) v.push_back(tx_q[i]);
            else exp_frame = 1'b1;
        end
        nw = v.size() / 4;
        for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(32'(w % Words));
            exp_data.push_back({v[4*w+3], v[4*w+2], v[4*w+1], v[4*w]});
        end
        exp_wrap    = (nw > int'(Words));
        exp_partial = (v.size() % 4) != 0;
        exp_any     = tx_q.size() > 0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, " write count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < obs_addr.size()) begin
                check($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
                check($sformatf("%s wdata[%0d]", tag, i), obs_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic finish_load(input string tag);
        for (int i = 0; i < 400 && boot_done !== 1'b1; i++) @(negedge clk);
        build_model();
        check({tag, " done"}, 32'(boot_done), 32'(exp_any));
        check({tag, " busy"}, 32'(boot_busy), 32'(!exp_any));
        check({tag, " err_frame"}, 32'(err_frame), 32'(exp_frame));
        check({tag, " err_partial"}, 32'(err_partial), 32'(exp_partial));
        check({tag, " err_wrap"}, 32'(err_wrap), 32'(exp_wrap));
        compare_writes(tag);
    endtask

    initial begin
        // 1: single word, then timeout window.
        do_reset("t1 reset", 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (100) @(negedge clk);
        check("t1 busy before timeout", 32'(boot_busy), 32'd1);
        check("t1 done before timeout", 32'(boot_done), 32'd0);
        finish_load("t1");
        if (obs_data.size() == 1) check("t1 fixed word", obs_data[0], 32'h1234_5678);

        // 2: nine words, address wraps on the last.
        do_reset("t2 reset", 1'b1);
        send_random(28);
        check("t2 no wrap after 7 words", 32'(err_wrap), 32'd0);
        send_random(8);
        finish_load("t2");

        // 3: framing error byte then a good word.
        do_reset("t3 reset", 1'b1);
        send_byte(8'hAA, 1'b0);
        send_random(4);
        finish_load("t3");

        // 4: short glitch on rx is not a byte and does not arm the timeout.
        do_reset("t4 reset", 1'b1);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t4 busy", 32'(boot_busy), 32'd1);
        check("t4 done", 32'(boot_done), 32'd0);
        check("t4 err_frame", 32'(err_frame), 32'd0);
        check("t4 writes", 32'(obs_addr.size()), 32'd0);

        // 5: two bytes only -> partial word discarded.
        do_reset("t5 reset", 1'b1);
        send_random(2);
        finish_load("t5");

        // 6: reset in the middle of the third byte of the second word.
        do_reset("t6 reset", 1'b1);
        send_random(4);
        send_random(2);
        repeat (10) @(negedge clk);
        check("t6 pre-reset writes", 32'(obs_addr.size()), 32'd1);
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'($urandom));
        resetb = 1'b0;
        rx     = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("t6 mid-load reset", 1'b1);
        resetb = 1'b1;
        clear_queues();
        repeat (2) @(negedge clk);
        send_random(4);
        finish_load("t6 reload");

        // 6b: bypass with enable low.
        do_reset("t6 bypass reset", 1'b0);
        send_random(4);
        repeat (200) @(negedge clk);
        check("t6 bypass busy", 32'(boot_busy), 32'd0);
        check("t6 bypass done", 32'(boot_done), 32'd0);
        check("t6 bypass writes", 32'(obs_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
